// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into a 32-bit word
// (bc[31:30], ct[29], opcode[28:24], payload[23:0]), rejects illegal
// field sets and buffers legal words in a small output FIFO.
module instr_encoder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ALU_OP_MAX = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_bc,
    input  logic             in_ct,
    input  logic [4:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [13:0]      in_imm,
    input  logic [18:0]      in_jimm,
    input  logic [23:0]      in_sysop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             err_illegal,
    output logic [CNT_W-1:0] enc_count,
    output logic [7:0]       err_count
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};
    localparam logic [4:0]  ALU_MAX = 5'(ALU_OP_MAX);

    // Build the payload from the field set selected by {bc,ct}.
    function automatic logic [23:0] pack_payload(
        input logic [2:0]  cls,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [13:0] imm,
        input logic [18:0] jimm,
        input logic [23:0] sysop
    );
        logic [23:0] p;
        case (cls)
            3'b000:          p = {rd, rs1, rs2, 9'd0};
            3'b001, 3'b010:  p = {rd, rs1, imm};
            3'b011, 3'b100:  p = {rs2, rs1, imm};
            3'b101:          p = {rd, jimm};
            3'b110:          p = sysop;
            default:         p = 24'd0;
        endcase
        return p;
    endfunction

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic             err_illegal_q;
    logic [CNT_W-1:0] enc_count_q;
    logic [7:0]       err_count_q;

    logic             full_s;
    logic             empty_s;
    logic             illegal_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic [31:0]      word_s;

    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_s = (wr_ptr_q == rd_ptr_q);

    assign in_ready    = !full_s;
    assign out_valid   = !empty_s;
    assign err_illegal = err_illegal_q;
    assign enc_count   = enc_count_q;
    assign err_count   = err_count_q;

    // Legality check and word assembly for the presented field set.
    always_comb begin
        illegal_s = 1'b0;
        if ((in_bc == 2'b00) && (in_opcode > ALU_MAX)) begin
            illegal_s = 1'b1;
        end else if ({in_bc, in_ct} == 3'b111) begin
            illegal_s = 1'b1;
        end else begin
            illegal_s = 1'b0;
        end
        word_s = {in_bc, in_ct, in_opcode,
                  pack_payload({in_bc, in_ct}, in_rd, in_rs1, in_rs2,
                               in_imm, in_jimm, in_sysop)};
    end

    assign accept_s = in_valid && !full_s;
    assign push_s   = accept_s && !illegal_s;
    assign pop_s    = !empty_s && out_ready;

    // Next pointer values; each advances independently so push+pop keeps occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_INC;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_INC;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Head of the FIFO is driven from storage only; zero when nothing is buffered.
    always_comb begin
        out_instr = 32'd0;
        if (empty_s) begin
            out_instr = 32'd0;
        end else begin
            out_instr = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    // Pointer, error pulse and counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            err_illegal_q <= 1'b0;
            enc_count_q   <= '0;
            err_count_q   <= 8'd0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            err_illegal_q <= accept_s && illegal_s;
            if (push_s) begin
                enc_count_q <= enc_count_q + CNT_W'(1);
            end
            if (accept_s && illegal_s && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    // FIFO storage; cleared on reset so stale words can never resurface.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= word_s;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed stimulus with a queue-based reference model
// and a per-cycle compare process, plus literal expectations.
module tb_instr_encoder;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_bc = 2'd0;
    logic        in_ct = 1'b0;
    logic [4:0]  in_opcode = 5'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_rs1 = 5'd0;
    logic [4:0]  in_rs2 = 5'd0;
    logic [13:0] in_imm = 14'd0;
    logic [18:0] in_jimm = 19'd0;
    logic [23:0] in_sysop = 24'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        err_illegal;
    logic [15:0] enc_count;
    logic [7:0]  err_count;

    int checks = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    // reference model state
    logic [31:0] exp_q [$];
    int          exp_enc = 0;
    int          exp_err = 0;
    bit          exp_pulse = 1'b0;

    instr_encoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_bc(in_bc), .in_ct(in_ct), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_jimm(in_jimm), .in_sysop(in_sysop),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .err_illegal(err_illegal), .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    // Word value from the field rules, using plain arithmetic.
    function automatic logic [31:0] model_word(input int bc, input int ct, input int op,
        input int rd, input int rs1, input int rs2, input int imm, input int jimm, input int sysop);
        longint p;
        case (bc * 2 + ct)
            0:       p = rd * 524288 + rs1 * 16384 + rs2 * 512;
            1, 2:    p = rd * 524288 + rs1 * 16384 + imm;
            3, 4:    p = rs2 * 524288 + rs1 * 16384 + imm;
            5:       p = rd * 524288 + jimm;
            6:       p = sysop;
            default: p = 0;
        endcase
        return 32'(longint'(bc) * 1073741824 + longint'(ct) * 536870912
                   + longint'(op) * 16777216 + p);
    endfunction

    function automatic bit model_legal(input int bc, input int ct, input int op);
        return !((bc == 0 && op > 8) || (bc == 3 && ct == 1));
    endfunction

    // Reference model: handshakes decided from the model's own occupancy.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            exp_enc = 0;
            exp_err = 0;
            exp_pulse = 1'b0;
        end else begin
            bit acc;
            bit ill;
            acc = in_valid && (exp_q.size() < D);
            ill = !model_legal(int'(in_bc), int'(in_ct), int'(in_opcode));
            if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
            if (acc && !ill) begin
                exp_q.push_back(model_word(int'(in_bc), int'(in_ct), int'(in_opcode),
                    int'(in_rd), int'(in_rs1), int'(in_rs2), int'(in_imm),
                    int'(in_jimm), int'(in_sysop)));
                exp_enc = (exp_enc + 1) % 65536;
            end
            if (acc && ill && exp_err < 255) exp_err++;
            exp_pulse = acc && ill;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < D});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
            chk("out_instr", out_instr, (exp_q.size() > 0) ? exp_q[0] : 32'd0);
            chk("err_illegal", {31'd0, err_illegal}, {31'd0, exp_pulse});
            chk("enc_count", {16'd0, enc_count}, 32'(exp_enc));
            chk("err_count", {24'd0, err_count}, 32'(exp_err));
        end
    end

    task automatic drive(input int bc, input int ct, input int op, input int rd,
        input int rs1, input int rs2, input int imm, input int jimm, input int sysop);
        in_bc = 2'(bc); in_ct = 1'(ct); in_opcode = 5'(op);
        in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
        in_imm = 14'(imm); in_jimm = 19'(jimm); in_sysop = 24'(sysop);
        in_valid = 1'b1;
    endtask

    // Hold the current request until the model says it is taken, then drop it.
    task automatic wait_accept();
        int n = 0;
        while (exp_q.size() >= D && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send(input int bc, input int ct, input int op, input int rd,
        input int rs1, input int rs2, input int imm, input int jimm, input int sysop);
        drive(bc, ct, op, rd, rs1, rs2, imm, jimm, sysop);
        wait_accept();
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            $display("FAIL drain_timeout: got words left expected empty within 100 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        // model pinned against hand-computed words
        chk("model_rtype", model_word(0, 0, 0, 3, 1, 2, 0, 0, 0), 32'h00184400);
        chk("model_itype", model_word(0, 1, 0, 3, 1, 0, 14'h0400, 0, 0), 32'h20184400);
        chk("model_jump",  model_word(2, 1, 0, 1, 0, 0, 0, 19'h7FFFF, 0), 32'hA00FFFFF);
        chk("model_sys",   model_word(3, 0, 3, 0, 0, 0, 0, 0, 24'hABCDEF), 32'hC3ABCDEF);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);

        // single R-type, one cycle latency
        out_ready = 1'b1;
        send(0, 0, 0, 3, 1, 2, 0, 0, 0);
        chk("rtype_word", out_instr, 32'h00184400);
        chk("rtype_enc", {16'd0, enc_count}, 32'd1);
        @(negedge clk);

        // four formats buffered then drained in order
        out_ready = 1'b0;
        send(0, 0, 0, 3, 1, 2, 0, 0, 0);
        send(0, 1, 0, 3, 1, 0, 14'h0400, 0, 0);
        send(2, 1, 0, 1, 0, 0, 0, 19'h7FFFF, 0);
        send(3, 0, 3, 0, 0, 0, 0, 0, 24'hABCDEF);
        chk("order0", out_instr, 32'h00184400);
        out_ready = 1'b1;
        @(negedge clk); chk("order1", out_instr, 32'h20184400);
        @(negedge clk); chk("order2", out_instr, 32'hA00FFFFF);
        @(negedge clk); chk("order3", out_instr, 32'hC3ABCDEF);
        @(negedge clk); chk("order_empty", {31'd0, out_valid}, 32'd0);

        // illegal requests
        send(0, 0, 9, 1, 1, 1, 0, 0, 0);
        chk("ill_pulse1", {31'd0, err_illegal}, 32'd1);
        chk("ill_noout1", {31'd0, out_valid}, 32'd0);
        send(3, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("ill_pulse2", {31'd0, err_illegal}, 32'd1);
        chk("ill_errcnt", {24'd0, err_count}, 32'd2);
        chk("ill_enccnt", {16'd0, enc_count}, 32'd5);
        @(negedge clk);
        chk("ill_pulse_end", {31'd0, err_illegal}, 32'd0);

        // backpressure: 5 requests, 5th held while full
        out_ready = 1'b0;
        send(0, 0, 0, 3, 1, 2, 0, 0, 0);
        for (int i = 1; i < 4; i++) send(0, 0, i, i, i + 1, i + 2, 0, 0, 0);
        chk("bp_full", {31'd0, in_ready}, 32'd0);
        drive(1, 1, 7, 0, 4, 9, 14'h3FFF, 0, 0);
        repeat (3) @(negedge clk);
        chk("bp_held_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_head", out_instr, 32'h00184400);
        out_ready = 1'b1;
        wait_accept();
        drain();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // simultaneous push/pop at occupancy 2
        out_ready = 1'b0;
        send(0, 1, 2, 5, 6, 0, 14'h1234, 0, 0);
        send(1, 0, 1, 7, 8, 0, 14'h0042, 0, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, i % 9, i, 31 - i, i + 3, 0, 0, 0);
            @(negedge clk);
            chk("pp_occupancy", 32'(exp_q.size()), 32'd2);
        end
        in_valid = 1'b0;
        drain();
        chk("pp_enccnt", {16'd0, enc_count}, 32'd22);

        // asynchronous reset with 3 words buffered
        out_ready = 1'b0;
        send(0, 0, 1, 1, 1, 1, 0, 0, 0);
        send(0, 0, 2, 2, 2, 2, 0, 0, 0);
        send(0, 0, 3, 3, 3, 3, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_enc", {16'd0, enc_count}, 32'd0);
        chk("rst_err", {24'd0, err_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        send(0, 0, 0, 3, 1, 2, 0, 0, 0);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_word", out_instr, 32'h00184400);
        chk("post_rst_enc", {16'd0, enc_count}, 32'd1);
        @(negedge clk);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Packs decoded instruction fields into a 32-bit instruction word. It is the inverse of the instruction decoder.
- Checks each field set for legality, drops illegal requests, and buffers legal words in a small FIFO.
- Sits between the test/program generator (or assembler front end) and instruction memory or the fetch path.
- Word layout is identical to the decoder's: bc[31:30], ct[29], opcode[28:24], payload[23:0].

Parameters:
- FIFO_DEPTH, 4, output buffer entries (power of 2, ≥2).
- ALU_OP_MAX, 8, highest legal ALU opcode (0=ADD … 8=OR).
- CNT_W, 16, width of the encoded-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  field set valid.
- in_ready  out  1  encoder can accept a field set.
- in_bc  in  2  bit class: 00 ALU, 01 mem, 10 control, 11 system.
- in_ct  in  1  class type: ALU R/I, mem load/store, ctrl branch/jump, system must be 0.
- in_opcode  in  5  opcode.
- in_rd, in_rs1, in_rs2  in  5 each  register addresses.
- in_imm  in  14  immediate.
- in_jimm  in  19  jump immediate.
- in_sysop  in  24  system operation field.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer takes word.
- out_instr  out  32  encoded instruction (FIFO head).
- err_illegal  out  1  one-cycle pulse when an illegal request is accepted.
- enc_count  out  CNT_W  count of legal words pushed, wraps.
- err_count  out  8  count of illegal requests, saturates at 255.

Behaviour:
- Payload packing by {bc,ct}:
  - 00_0 R-type: rd[23:19], rs1[18:14], rs2[13:9], [8:0]=0.
  - 00_1 I-type and 01_0 load: rd[23:19], rs1[18:14], imm[13:0].
  - 01_1 store and 10_0 branch: rs2[23:19], rs1[18:14], imm[13:0].
  - 10_1 jump: rd[23:19], jimm[18:0].
  - 11_0 system: sysop[23:0].
  - Unused inputs are ignored.
- Illegal requests:
  - bc=00 with opcode > ALU_OP_MAX.
  - {bc,ct}=11_1.
- Input handshake: accept when in_valid && in_ready.
  - in_ready = !full, combinational from FIFO state only.
  - Illegal requests are accepted (handshake completes) but not pushed. err_illegal pulses the following cycle, err_count increments.
- Output handshake: pop when out_valid && out_ready.
  - out_valid = !empty.
  - out_instr is the registered FIFO head and holds stable while out_valid && !out_ready.
  - out_instr is 0 when empty.
- Latency: a legal word accepted in cycle N is visible on out_instr/out_valid in cycle N+1 when the FIFO was empty. There is no combinational in→out path.
- Simultaneous push and pop: allowed when not full. Occupancy is unchanged and order is preserved.
  - When full, in_ready=0 even if out_ready=1 in the same cycle (no bypass).
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full/empty are derived from the MSB compare.
- enc_count increments once per legal push and wraps at 2^CNT_W.
- Reset (asynchronous, any time including mid-transfer):
  - FIFO is emptied.
  - out_valid=0, out_instr=0, in_ready=1 after release, err_illegal=0, enc_count=0, err_count=0.
  - In-flight words are discarded.

Test Plan:
- R-type ADD: bc=00, ct=0, op=0, rd=3, rs1=1, rs2=2, out_ready=1 → out_instr=32'h00184400 one cycle after accept; enc_count=1.
- I-type ADD, imm=14'h0400, rd=3, rs1=1 → 32'h20184400. Jump, rd=1, jimm=19'h7FFFF → 32'hA00FFFFF. System, op=3, sysop=24'hABCDEF → 32'hC3ABCDEF. All four arrive in order.
- Illegal: bc=00, op=9, then {bc,ct}=11_1 → both handshaken, no out_valid, err_illegal pulses twice, err_count=2, enc_count unchanged.
- Backpressure: out_ready=0, send 5 legal requests →
  - in_ready drops after the 4th accept and the 5th is held.
  - out_instr stays at the 1st word.
  - Release out_ready → all 5 words drain in order, out_valid falls after the 5th.
- Simultaneous push/pop at occupancy 2 for 10 cycles → occupancy stays 2, no loss or duplication, pointer wrap exercised.
- Assert rst asynchronously with 3 words buffered → out_valid=0 and counters=0 immediately. After release, the first new request encodes correctly with latency 1.
